// File: rtl/mux_sel_arbiter.sv
// Round-robin feeder for the 2:1 mux path: ch0 passes through, ch1 is transformed to (d<<2)+1,
// and one registered word per cycle is presented with its source select bit.
module mux_sel_arbiter #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in0_valid,
    output logic          in0_ready,
    input  logic [DW-1:0] in0_data,
    input  logic          in1_valid,
    output logic          in1_ready,
    input  logic [DW-1:0] in1_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sel,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] xfer_cnt0,
    output logic [CW-1:0] xfer_cnt1
);

    localparam logic [DW-1:0] DATA_ONE = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    logic          last_grant;
    logic          accept;
    logic          grant0;
    logic          grant1;
    logic          hs0;
    logic          hs1;
    logic [DW-1:0] xform;

    // Contention goes to the channel that was not served last; a lone requester always wins.
    assign accept    = !out_valid || out_ready;
    assign grant0    = in0_valid && (!in1_valid || last_grant);
    assign grant1    = in1_valid && (!in0_valid || !last_grant);
    assign in0_ready = accept && grant0;
    assign in1_ready = accept && grant1;
    assign hs0       = in0_valid && in0_ready;
    assign hs1       = in1_valid && in1_ready;
    assign xform     = (in1_data << 2) + DATA_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_sel    <= 1'b0;
            out_data   <= '0;
            last_grant <= 1'b1;
        end else if (hs0) begin
            out_valid  <= 1'b1;
            out_sel    <= 1'b0;
            out_data   <= in0_data;
            last_grant <= 1'b0;
        end else if (hs1) begin
            out_valid  <= 1'b1;
            out_sel    <= 1'b1;
            out_data   <= xform;
            last_grant <= 1'b1;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Counters stick at their maximum rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt0 <= '0;
            xfer_cnt1 <= '0;
        end else begin
            if (hs0 && xfer_cnt0 != CNT_MAX) xfer_cnt0 <= xfer_cnt0 + CNT_ONE;
            if (hs1 && xfer_cnt1 != CNT_MAX) xfer_cnt1 <= xfer_cnt1 + CNT_ONE;
        end
    end

endmodule
